// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand feed controller.
// Provides the FSM state encoding, the counter width function and a lane-slice macro.
`ifndef SYSTOLIC_PKG_SV
`define SYSTOLIC_PKG_SV

// Selects lane i of a packed N*w bus.
`define SYS_LANE(i, w) ((i)*(w)) +: (w)

package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Width needed to hold the values 0..k.
    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

`endif

// File: rtl/systolic_feed_ctrl_valid_delay_pipe.sv
// Shift register that delays the read strobe to qualify the output register.
// Ports: clk, rst (async active-low), in_valid, load_en (stage 1), out_valid (last stage).
module valid_delay_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic load_en,
    output logic out_valid
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], in_valid};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign load_en   = pipe_q[0];
    assign out_valid = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Reads one operand tile column by column and forwards it to the row skew chains.
// Ports: clk, rst, start, k_len, hold, rd_en/rd_addr/rd_data, out_data(_valid), busy, done.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int N            = 4,
    parameter int DATA_W       = 32,
    parameter int K_MAX        = 16,
    parameter int DRAIN_CYCLES = 2 * N - 1,
    localparam int CNT_W       = cnt_w(K_MAX)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    k_len,
    input  logic                hold,
    output logic                rd_en,
    output logic [CNT_W-1:0]    rd_addr,
    input  logic [N*DATA_W-1:0] rd_data,
    output logic [N*DATA_W-1:0] out_data,
    output logic                out_data_valid,
    output logic                busy,
    output logic                done
);

    localparam int DR_W = cnt_w(DRAIN_CYCLES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic [DR_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [N*DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]    k_eff;
    logic                load_en;

    assign k_eff = (k_len > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_len;

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        k_d         = k_q;
        drain_cnt_d = drain_cnt_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    col_cnt_d = '0;
                    if (k_eff != '0) begin
                        k_d     = k_eff;
                        state_d = S_FEED;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FEED: begin
                rd_en   = !hold;
                rd_addr = col_cnt_q;
                if (!hold) begin
                    col_cnt_d = col_cnt_q + CNT_W'(1);
                    if (col_cnt_q == k_q - CNT_W'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DR_W'(1);
                if (drain_cnt_q == DR_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d = load_en ? rd_data : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            col_cnt_q   <= '0;
            k_q         <= '0;
            drain_cnt_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            k_q         <= k_d;
            drain_cnt_q <= drain_cnt_d;
            data_q      <= data_d;
        end
    end

    valid_delay_pipe #(
        .DEPTH(2)
    ) u_vpipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_en),
        .load_en  (load_en),
        .out_valid(out_data_valid)
    );

    assign out_data = data_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomised bench for systolic_feed_ctrl against a cycle-count reference model.
// Drives inputs 1ns after the rising edge and samples on the falling edge.
module tb_systolic_feed_ctrl;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int KMAX  = 16;
    localparam int DRAIN = 7;
    localparam int BW    = N * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    k_len = '0;
    logic          hold = 1'b0;
    logic          rd_en;
    logic [4:0]    rd_addr;
    logic [BW-1:0] rd_data = '0;
    logic [BW-1:0] out_data;
    logic          out_data_valid;
    logic          busy;
    logic          done;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [BW-1:0] mem [KMAX];

    typedef struct {
        int            due;
        logic [BW-1:0] d;
    } exp_t;
    exp_t q[$];

    int done_obs;
    int reads_obs;

    systolic_feed_ctrl #(
        .N(N), .DATA_W(DW), .K_MAX(KMAX), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .k_len         (k_len),
        .hold          (hold),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .out_data      (out_data),
        .out_data_valid(out_data_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Operand buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [BW-1:0] got,
                       input logic [BW-1:0] want);
        n_asserts++;
        assert (got === want) else begin
            n_fails++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < KMAX; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One tile: cycle 0 asserts start; random hold and stray starts after.
    task automatic run_tile(input int klen, input int hold_pct);
        int k, cyc, nxt, done_cyc;
        bit feed, exp_rd, exp_v;
        k        = (klen > KMAX) ? KMAX : klen;
        q.delete();
        done_obs  = -1;
        reads_obs = 0;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = 5'(klen);
        hold  = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_rd_en", rd_en, 0);
        cyc      = 1;
        nxt      = 0;
        feed     = (k != 0);
        done_cyc = (k == 0) ? 1 : -1;
        while (!(done_cyc >= 0 && cyc > done_cyc) && cyc < 200) begin
            @(posedge clk); #1;
            hold  = ($urandom_range(99) < hold_pct);
            start = ($urandom_range(3) == 0);
            k_len = 5'd5;
            exp_rd = feed && !hold;
            @(negedge clk);
            chk("rd_en", rd_en, exp_rd);
            if (exp_rd) chk("rd_addr", rd_addr, nxt);
            if (rd_en) reads_obs++;
            chk("busy", busy, 1);
            chk("done", done, (cyc == done_cyc));
            if (done) done_obs = cyc;
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", out_data_valid, exp_v);
            if (exp_v) begin
                chk("out_data", out_data, q[0].d);
                void'(q.pop_front());
            end
            if (exp_rd) begin
                q.push_back('{cyc + 2, mem[nxt]});
                nxt++;
                if (nxt == k) begin
                    feed     = 0;
                    done_cyc = cyc + DRAIN + 1;
                end
            end
            cyc++;
        end
        chk("timeout", (cyc < 200), 1);
        @(posedge clk); #1;
        start = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);
        chk("end_valid", out_data_valid, 0);
        chk("end_queue", q.size(), 0);
        chk("reads", reads_obs, k);
    endtask

    initial begin
        fill_mem();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_valid", out_data_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;

        // Basic and zero-length tiles.
        run_tile(4, 0);
        chk("basic_done_cyc", done_obs, 12);
        run_tile(0, 0);
        chk("zero_done_cyc", done_obs, 1);

        // Held tiles with random stalls and stray starts.
        for (int i = 0; i < 6; i++) begin
            fill_mem();
            run_tile($urandom_range(1, 10), 35);
        end

        // Max length and clamp.
        run_tile(16, 0);
        chk("max_done_cyc", done_obs, 16 + DRAIN + 1);
        fill_mem();
        run_tile(20, 0);
        chk("clamp_done_cyc", done_obs, 16 + DRAIN + 1);

        // Reset during the second read of a k=8 tile.
        @(posedge clk); #1;
        start = 1'b1;
        k_len = 5'd8;
        hold  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_rd", rd_en, 1);
        chk("pre_rst_addr", rd_addr, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_rd", rd_en, 0);
        chk("mid_rst_addr", rd_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_data_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_valid", out_data_valid, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        fill_mem();
        run_tile(4, 0);
        chk("after_rst_done_cyc", done_obs, 12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule
